// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between Rename and ROB/RS: routes the head entry to one RS channel and allocates its ROB slot.
// Optional DISPATCH_BYPASS_EN macro lets an instruction dispatch combinationally from ren_* when the queue is empty.
module dispatch_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_FU    = 3,
    parameter int PAYLOAD_W = 64,
    parameter int PREG_W    = 6,
    parameter int ROB_TAG_W = 4,
    localparam int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 ren_valid_i,
    output logic                 ren_ready_o,
    input  logic [PAYLOAD_W-1:0] ren_payload_i,
    input  logic [FU_W-1:0]      ren_fu_i,
    input  logic [PREG_W-1:0]    ren_rs1_p_i,
    input  logic [PREG_W-1:0]    ren_rs2_p_i,
    input  logic [PREG_W-1:0]    ren_rd_new_p_i,
    input  logic [PREG_W-1:0]    ren_rd_old_p_i,
    input  logic                 rob_full_i,
    input  logic [ROB_TAG_W-1:0] rob_alloc_tag_i,
    output logic                 rob_push_o,
    output logic [PAYLOAD_W-1:0] rob_payload_o,
    output logic [PREG_W-1:0]    rob_rd_new_p_o,
    output logic [PREG_W-1:0]    rob_rd_old_p_o,
    input  logic [NUM_FU-1:0]    rs_ready_i,
    output logic [NUM_FU-1:0]    rs_valid_o,
    output logic [PAYLOAD_W-1:0] dsp_payload_o,
    output logic [PREG_W-1:0]    dsp_rs1_p_o,
    output logic [PREG_W-1:0]    dsp_rs2_p_o,
    output logic [PREG_W-1:0]    dsp_rd_p_o,
    output logic [ROB_TAG_W-1:0] dsp_rob_tag_o,
    output logic [CNT_W-1:0]     count_o,
    output logic [15:0]          rob_stall_cnt_o,
    output logic [15:0]          rs_stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [FU_W-1:0]      fu;
        logic [PREG_W-1:0]    rs1;
        logic [PREG_W-1:0]    rs2;
        logic [PREG_W-1:0]    rd_new;
        logic [PREG_W-1:0]    rd_old;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       rob_stall_cnt_q, rob_stall_cnt_d;
    logic [15:0]       rs_stall_cnt_q, rs_stall_cnt_d;

    entry_t in_e, head_e;
    logic   head_valid, byp, legal, rs_rdy_sel;
    logic   fire, drop, pop, push, wr, rd;

    always_comb begin
        in_e.payload = ren_payload_i;
        in_e.fu      = ren_fu_i;
        in_e.rs1     = ren_rs1_p_i;
        in_e.rs2     = ren_rs2_p_i;
        in_e.rd_new  = ren_rd_new_p_i;
        in_e.rd_old  = ren_rd_old_p_i;

        head_e     = mem_q[head_q];
        head_valid = (count_q != '0);
`ifdef DISPATCH_BYPASS_EN
        byp = (count_q == '0) && ren_valid_i && !flush_i;
        if (byp) begin
            head_e     = in_e;
            head_valid = 1'b1;
        end
`else
        byp = 1'b0;
`endif

        legal      = 1'b0;
        rs_rdy_sel = 1'b0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            if (head_e.fu == FU_W'(f)) begin
                legal      = 1'b1;
                rs_rdy_sel = rs_ready_i[f];
            end
        end

        fire = head_valid && !flush_i && !rob_full_i && legal && rs_rdy_sel;
        // A bypassed illegal instruction is enqueued and dropped from storage next cycle.
        drop = head_valid && !flush_i && !legal && !byp;
        pop  = fire || drop;

        ren_ready_o = !flush_i && ((count_q < CNT_W'(DEPTH)) || pop);
        push        = ren_valid_i && ren_ready_o && !flush_i;
        wr          = push && !(byp && fire);
        rd          = drop || (fire && !byp);

        rob_push_o = fire;
        rs_valid_o = '0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            rs_valid_o[f] = fire && (head_e.fu == FU_W'(f));
        end

        rob_payload_o  = head_e.payload;
        rob_rd_new_p_o = head_e.rd_new;
        rob_rd_old_p_o = head_e.rd_old;
        dsp_payload_o  = head_e.payload;
        dsp_rs1_p_o    = head_e.rs1;
        dsp_rs2_p_o    = head_e.rs2;
        dsp_rd_p_o     = head_e.rd_new;
        dsp_rob_tag_o  = rob_alloc_tag_i;

        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr) begin
                mem_d[tail_q] = in_e;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (rd) head_d = head_q + PTR_W'(1);
            if (wr && !rd)      count_d = count_q + CNT_W'(1);
            else if (!wr && rd) count_d = count_q - CNT_W'(1);
        end

        rob_stall_cnt_d = rob_stall_cnt_q;
        rs_stall_cnt_d  = rs_stall_cnt_q;
        if (head_valid && !flush_i && rob_full_i && (rob_stall_cnt_q != '1))
            rob_stall_cnt_d = rob_stall_cnt_q + 16'd1;
        if (head_valid && !flush_i && !rob_full_i && legal && !rs_rdy_sel && (rs_stall_cnt_q != '1))
            rs_stall_cnt_d = rs_stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            rob_stall_cnt_q <= '0;
            rs_stall_cnt_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            rob_stall_cnt_q <= rob_stall_cnt_d;
            rs_stall_cnt_q  <= rs_stall_cnt_d;
        end
    end

    assign count_o         = count_q;
    assign rob_stall_cnt_o = rob_stall_cnt_q;
    assign rs_stall_cnt_o  = rs_stall_cnt_q;

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised dispatch stage between Rename and the ROB/reservation stations. It replaces the single-entry skid buffer with a DEPTH-entry in-order FIFO, routes the head instruction to one of NUM_FU reservation-station channels, and allocates its ROB slot in the same cycle. It adds a mispredict flush and saturating stall-reason counters for performance analysis.

## Interface
- DEPTH, 4: queue entries; power of 2, ≥2
- NUM_FU, 3: reservation-station channels (0=ALU, 1=LSU, 2=BRANCH by convention)
- PAYLOAD_W, 64: opaque control payload width (pc, imm, ALU op, mem flags, branch/jump bits)
- PREG_W, 6: physical register index width
- ROB_TAG_W, 4: ROB tag width
- FU_W, derived: $clog2(NUM_FU), min 1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  mispredict flush; empties queue
- ren_valid_i  in  1  Rename has an instruction
- ren_ready_o  out  1  queue accepts this cycle
- ren_payload_i  in  PAYLOAD_W  control payload
- ren_fu_i  in  FU_W  target channel index
- ren_rs1_p_i / ren_rs2_p_i / ren_rd_new_p_i / ren_rd_old_p_i  in  PREG_W each  renamed registers
- rob_full_i  in  1  ROB cannot allocate
- rob_alloc_tag_i  in  ROB_TAG_W  tag for the next allocation
- rob_push_o  out  1  allocate ROB entry
- rob_payload_o  out  PAYLOAD_W  head payload to ROB
- rob_rd_new_p_o / rob_rd_old_p_o  out  PREG_W  head rd new/old
- rs_ready_i  in  NUM_FU  per-channel RS has space
- rs_valid_o  out  NUM_FU  one-hot issue strobe
- dsp_payload_o  out  PAYLOAD_W  head payload to RS
- dsp_rs1_p_o / dsp_rs2_p_o / dsp_rd_p_o  out  PREG_W  head registers
- dsp_rob_tag_o  out  ROB_TAG_W  equals rob_alloc_tag_i
- count_o  out  $clog2(DEPTH)+1  occupancy
- rob_stall_cnt_o / rs_stall_cnt_o  out  16  saturating stall counters

## Operation
- Circular FIFO with head/tail pointers (log2 DEPTH, natural wrap) and a separate count register.
- push = ren_valid_i & ren_ready_o & !flush_i. Entry stores payload, fu index, and the four register indices.
- fire = head valid & !flush_i & !rob_full_i & rs_ready_i[head_fu], only when head_fu < NUM_FU.
- On fire: rob_push_o=1, rs_valid_o[head_fu]=1, head pops.
- Illegal head_fu (≥NUM_FU): head pops with no ROB push and no RS strobe. Drop needs only head valid & !flush_i.
- ren_ready_o = !flush_i & (count<DEPTH | pop). A full queue accepts a push when the head pops in the same cycle. Count is unchanged on simultaneous push+pop.
- Data outputs (dsp_*, rob_* fields) always reflect the head entry. They are only meaningful while a strobe is asserted.
- flush_i: next edge sets head=tail=count=0. In the flush cycle ren_ready_o, rob_push_o and rs_valid_o are forced 0. Flush wins over push and pop.
- rob_stall_cnt increments when head valid & !flush_i & rob_full_i.
- rs_stall_cnt increments when head valid & !flush_i & !rob_full_i & legal head_fu & !rs_ready_i[head_fu].
- Both counters saturate at 16'hFFFF. Only reset clears them; flush does not.

## Timing
- Reset (rst_n low, async): count_o=0, pointers=0, storage=0, counters=0, rob_push_o=0, rs_valid_o=0. ren_ready_o=1 once rst_n releases and flush_i=0.
- All strobes are combinational from registered state plus rob_full_i, rs_ready_i and flush_i. There is no combinational path from ren_* to any output except under the macro below.
- Latency without the macro: an instruction accepted at edge N can fire in cycle N+1 at the earliest. Throughput is 1/cycle sustained.
- Strict in-order dispatch. A stalled head blocks younger entries even when their channel is ready.

## Configuration
- DISPATCH_BYPASS_EN defined:
  - When count=0 and ren_valid_i & !flush_i, the head outputs and fire condition are taken combinationally from ren_* inputs.
  - If the instruction fires, it is not written. Otherwise it is enqueued normally.
  - Zero-cycle latency when empty.
- DISPATCH_BYPASS_EN undefined: all instructions pass through storage; minimum 1-cycle latency.

## Test plan
- Reset mid-operation: count=3, drop rst_n for 1 cycle → count_o=0, rs_valid_o=0, counters 0, ren_ready_o=1 after release.
- Fill/drain: DEPTH=4, rs_ready_i=0, push 5 instrs (fu=0,1,2,0,1) → ren_ready_o=0 after 4. Then rs_ready_i=3'b111 → rs_valid_o=001,010,100,001,010 on consecutive cycles with tags echoed.
- Full push+pop: count=4, head fires while ren_valid_i=1 → push accepted, count stays 4, tail wraps to 0.
- ROB stall: rob_full_i=1 for 10 cycles with head valid → no rob_push_o, rob_stall_cnt_o=10, rs_stall_cnt_o=0. Preset near saturation → holds at 16'hFFFF.
- Flush with concurrent push and ready RS: count=2, flush_i=1, ren_valid_i=1 → no strobes that cycle, count_o=0 next cycle, stall counters unchanged.
- Illegal fu=3 with NUM_FU=3 at head → popped in one cycle, rob_push_o=0, rs_valid_o=0. With DISPATCH_BYPASS_EN, empty queue and ready fu=1 → rs_valid_o=010 in the same cycle and count stays 0.
